// File: rtl/serial_frame_tx_1011.sv
// Serial frame transmitter for the 1011-sync link: sync word, payload MSB-first, optional parity, zero gap.
// Build option: define PARITY_EN to append one even-parity bit after the payload.
`timescale 1ns/1ps

module serial_frame_tx_1011 #(
    parameter int         DATA_W    = 8,
    parameter int         GAP_LEN   = 2,
    parameter logic [3:0] SYNC_WORD = 4'b1011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              d_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_LEN = (DATA_W > GAP_LEN) ? ((DATA_W > 4) ? DATA_W : 4)
                                                : ((GAP_LEN > 4) ? GAP_LEN : 4);
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
`ifdef PARITY_EN
        S_PAR  = 3'd3,
`endif
        S_GAP  = 3'd4
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [1:0]        sync_idx;

`ifdef PARITY_EN
    logic              parity_reg;
`endif

    // cnt_reg counts the bits still to come after the one currently on d_out
    assign sync_idx = cnt_reg[1:0] - 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            d_out      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
`ifdef PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (load_valid) begin
                        state_reg  <= S_SYNC;
                        cnt_reg    <= CNT_SYNC;
                        shift_reg  <= load_data;
                        d_out      <= SYNC_WORD[3];
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef PARITY_EN
                        parity_reg <= ^load_data;
`endif
                    end else begin
                        d_out <= 1'b0;
                    end
                end

                S_SYNC: begin
                    if (cnt_reg != '0) begin
                        d_out   <= SYNC_WORD[sync_idx];
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end else begin
                        state_reg <= S_DATA;
                        cnt_reg   <= CNT_DATA;
                        d_out     <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                    end
                end

                S_DATA: begin
                    if (cnt_reg != '0) begin
                        d_out     <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                        cnt_reg   <= cnt_reg - CNT_ONE;
                    end else begin
`ifdef PARITY_EN
                        state_reg <= S_PAR;
                        d_out     <= parity_reg;
`else
                        state_reg <= S_GAP;
                        cnt_reg   <= CNT_GAP;
                        d_out     <= 1'b0;
`endif
                    end
                end

`ifdef PARITY_EN
                S_PAR: begin
                    state_reg <= S_GAP;
                    cnt_reg   <= CNT_GAP;
                    d_out     <= 1'b0;
                end
`endif

                S_GAP: begin
                    d_out <= 1'b0;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end else begin
                        // The idle cycle that follows adds one more zero before any new sync
                        state_reg  <= S_IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        frame_done <= 1'b1;
                    end
                end

                default: begin
                    state_reg  <= S_IDLE;
                    cnt_reg    <= '0;
                    d_out      <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx_1011.sv
// Scoreboard bench for serial_frame_tx_1011: stimulus queues hand-computed frame bits, a monitor checks d_out.
`timescale 1ns/1ps

module tb_serial_frame_tx_1011;

    localparam int DATA_W  = 8;
    localparam int GAP_LEN = 2;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FLEN = 4 + DATA_W + P + GAP_LEN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_ready;
    logic              d_out;
    logic              busy;
    logic              frame_done;

    serial_frame_tx_1011 #(
        .DATA_W   (DATA_W),
        .GAP_LEN  (GAP_LEN),
        .SYNC_WORD(4'b1011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .d_out     (d_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         det_cnt  = 0;
    logic [3:0] det_hist = 4'b0000;
    logic       prev_last = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed frame images for the default parameters, first bit in the MSB
    function automatic logic [14:0] frame_vec(input logic [7:0] d);
        logic [14:0] v;
        v = '0;
`ifdef PARITY_EN
        case (d)
            8'hA5: v = 15'b1011_10100101_0_00;
            8'h3C: v = 15'b1011_00111100_0_00;
            8'hFF: v = 15'b1011_11111111_0_00;
            8'h5A: v = 15'b1011_01011010_0_00;
            8'h81: v = 15'b1011_10000001_0_00;
            8'hF0: v = 15'b1011_11110000_0_00;
            8'h07: v = 15'b1011_00000111_1_00;
            default: v = '0;
        endcase
`else
        case (d)
            8'hA5: v = {1'b0, 14'b1011_10100101_00};
            8'h3C: v = {1'b0, 14'b1011_00111100_00};
            8'hFF: v = {1'b0, 14'b1011_11111111_00};
            8'h5A: v = {1'b0, 14'b1011_01011010_00};
            8'h81: v = {1'b0, 14'b1011_10000001_00};
            8'hF0: v = {1'b0, 14'b1011_11110000_00};
            8'h07: v = {1'b0, 14'b1011_00000111_00};
            default: v = '0;
        endcase
`endif
        return v;
    endfunction

    task automatic push_frame(input logic [7:0] d);
        logic [14:0] v;
        v = frame_vec(d);
        for (int i = FLEN - 1; i >= 0; i--) begin
            exp_q.push_back('{b: v[i], last: (i == 0)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic send(input logic [7:0] d, input bit keep, output int acc_cyc);
        int n;
        n = 0;
        load_data  = d;
        load_valid = 1'b1;
        while (!load_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_timeout", 32'(n < 200), 1);
        push_frame(d);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        $display("accept data=%02h cyc=%0d", d, cyc);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", load_ready, 0);
        if (!keep) load_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 32'(n < 300), 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected bit per busy cycle, zeros while idle, frame_done right after a frame's last bit
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            det_hist  = 4'b0000;
            prev_last = 1'b0;
        end else begin
            check("ready_vs_busy", load_ready, !busy);
            det_hist = {det_hist[2:0], d_out};
            if (det_hist == 4'b1011) det_cnt++;
            if (frame_done) begin
                done_cnt++;
                $display("frame_done #%0d t=%0t", done_cnt, $time);
            end
            check("frame_done_timing", frame_done, prev_last);
            prev_last = 1'b0;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("d_out_bit", d_out, e.b);
                    prev_last = e.last;
                end
            end else begin
                check("idle_d_out", d_out, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n, d0, dn0;

        // Reset is asynchronous: outputs settle before any clock edge
        #2 rst = 1'b0;
        #1;
        check("rst_d_out", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", load_ready, 1);
        check("rst_frame_done", frame_done, 0);
        #20 rst = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: reset during the payload
        send(8'hFF, 1'b0, a1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_d_out", d_out, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_d_out", d_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", load_ready, 1);
        check("midrst_frame_done", frame_done, 0);
        exp_q.delete();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Test 2: single frame A5, detector sees exactly one sync
        d0  = det_cnt;
        dn0 = done_cnt;
        send(8'hA5, 1'b0, a1);
        wait_idle(n);
        check("frame_len_A5", n, FLEN);
        check("det_count_A5", det_cnt - d0, 1);
        check("done_count_A5", done_cnt - dn0, 1);
        check("ready_after_A5", load_ready, 1);

        // Test 3: back-to-back with load_valid held
        dn0 = done_cnt;
        send(8'h3C, 1'b1, a1);
        send(8'hFF, 1'b0, a2);
        check("b2b_spacing", a2 - a1, FLEN + 1);
        wait_idle(n);
        check("done_count_b2b", done_cnt - dn0, 2);

        // Test 4: load_valid during sync is ignored
        send(8'h5A, 1'b0, a1);
        load_data  = 8'h00;
        load_valid = 1'b1;
        repeat (3) begin
            check("ready_while_busy", load_ready, 0);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        wait_idle(n);

        // Test 5: abort mid-payload, then a clean frame
        send(8'hF0, 1'b0, a1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b0;
        #1;
        check("abort_d_out", d_out, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'h81, 1'b0, a1);
        wait_idle(n);
        check("frame_len_81", n, FLEN);

`ifdef PARITY_EN
        // Test 6: parity frames
        send(8'hA5, 1'b0, a1);
        wait_idle(n);
        check("frame_len_par_A5", n, FLEN);
        send(8'h07, 1'b0, a1);
        wait_idle(n);
        check("frame_len_par_07", n, FLEN);
`else
        send(8'h07, 1'b0, a1);
        wait_idle(n);
        check("frame_len_07", n, FLEN);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
